// File: rtl/prog_loader_if.sv
// prog_loader_if: byte-stream valid/ready handshake that feeds the program
// loader.
//   in_valid  source -> loader  byte available on in_data
//   in_data   source -> loader  stream byte
//   in_ready  loader -> source  loader accepts a byte this cycle
// A byte transfers on every clock edge where in_valid and in_ready are both high.
// Modports: master = byte source, slave = loader.
interface prog_loader_if;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready
    );
endinterface

// File: rtl/prog_loader.sv
// prog_loader: fills the core's instruction RAM from a length-prefixed,
// XOR-checksummed byte stream and keeps the core in reset until a complete,
// verified image has been written.
//
// Stream format: N[7:0], N[15:8], then N words of 4 little-endian bytes each,
// then one checksum byte equal to the XOR of every preceding byte.
//
// Ports:
//   clk           clock
//   rst           asynchronous active-high reset
//   start         single-cycle load request (honoured in IDLE/DONE/ERR only)
//   stream        byte-stream handshake (in_valid, in_data, in_ready)
//   imem_we       instruction RAM write strobe, one cycle per word
//   imem_waddr    write address
//   imem_wdata    write data (bits above INSTR_W-1 of each word dropped)
//   core_hold     high while the core must stay in reset (low only in DONE)
//   busy          load in progress
//   done          image loaded and checksum verified (sticky)
//   error         load aborted (sticky)
//   words_loaded  words written in the current/last load
module prog_loader #(
    parameter int ADDR_W  = 10,
    parameter int INSTR_W = 27
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    prog_loader_if.slave        stream,
    output logic                imem_we,
    output logic [ADDR_W-1:0]   imem_waddr,
    output logic [INSTR_W-1:0]  imem_wdata,
    output logic                core_hold,
    output logic                busy,
    output logic                done,
    output logic                error,
    output logic [ADDR_W:0]     words_loaded
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LEN_LO = 3'd1;
    localparam logic [2:0] S_LEN_HI = 3'd2;
    localparam logic [2:0] S_DATA   = 3'd3;
    localparam logic [2:0] S_CHECK  = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;
    localparam logic [2:0] S_ERR    = 3'd6;

    // Largest legal length: one full RAM image.
    localparam logic [16:0] MAX_WORDS = 17'd1 << ADDR_W;

    localparam logic [ADDR_W-1:0] ADDR_INC  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   COUNT_INC = {{ADDR_W{1'b0}}, 1'b1};

    // Running XOR checksum update.
    function automatic logic [7:0] checksum_next(input logic [7:0] sum,
                                                 input logic [7:0] data);
        return sum ^ data;
    endfunction

    // States in which the loader consumes stream bytes.
    function automatic logic is_busy_state(input logic [2:0] s);
        logic result;
        case (s)
            S_LEN_LO, S_LEN_HI, S_DATA, S_CHECK: result = 1'b1;
            default:                             result = 1'b0;
        endcase
        return result;
    endfunction

    logic [2:0]         state_r;
    logic [2:0]         state_next_s;
    logic               busy_r;
    logic               core_hold_r;
    logic               done_r;
    logic               error_r;
    logic [15:0]        len_r;
    logic [23:0]        asm_r;
    logic [7:0]         csum_r;
    logic [1:0]         byte_idx_r;
    logic               imem_we_r;
    logic [ADDR_W-1:0]  imem_waddr_r;
    logic [INSTR_W-1:0] imem_wdata_r;
    logic [ADDR_W:0]    words_loaded_r;

    logic               accept_s;
    logic               start_ok_s;
    logic [15:0]        len_full_s;
    logic               last_word_s;
    logic               word_done_s;
    logic [31:0]        word_s;

    assign accept_s   = stream.in_valid & busy_r;
    assign start_ok_s = start & ((state_r == S_IDLE) | (state_r == S_DONE) |
                                 (state_r == S_ERR));
    assign len_full_s = {stream.in_data, len_r[7:0]};
    assign word_s     = {stream.in_data, asm_r};
    assign word_done_s = accept_s & (state_r == S_DATA) & (byte_idx_r == 2'd3);
    // All earlier writes have retired by the time byte 3 of the next word
    // arrives, so words_loaded equals the index of the word being completed.
    assign last_word_s = ((17'(words_loaded_r) + 17'd1) == {1'b0, len_r});

    assign stream.in_ready = busy_r;
    assign busy            = busy_r;
    assign core_hold       = core_hold_r;
    assign done            = done_r;
    assign error           = error_r;
    assign imem_we         = imem_we_r;
    assign imem_waddr      = imem_waddr_r;
    assign imem_wdata      = imem_wdata_r;
    assign words_loaded    = words_loaded_r;

    // Next-state decode of the load sequencer.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_next_s = S_LEN_LO;
                end else begin
                    state_next_s = state_r;
                end
            end
            S_LEN_LO: begin
                if (accept_s) begin
                    state_next_s = S_LEN_HI;
                end else begin
                    state_next_s = state_r;
                end
            end
            S_LEN_HI: begin
                if (!accept_s) begin
                    state_next_s = state_r;
                end else if ({1'b0, len_full_s} > MAX_WORDS) begin
                    state_next_s = S_ERR;
                end else if (len_full_s == 16'd0) begin
                    state_next_s = S_CHECK;
                end else begin
                    state_next_s = S_DATA;
                end
            end
            S_DATA: begin
                // Leave as soon as the last byte is taken; its write strobe
                // still issues on the following cycle.
                if (word_done_s && last_word_s) begin
                    state_next_s = S_CHECK;
                end else begin
                    state_next_s = state_r;
                end
            end
            S_CHECK: begin
                if (!accept_s) begin
                    state_next_s = state_r;
                end else if (stream.in_data == csum_r) begin
                    state_next_s = S_DONE;
                end else begin
                    state_next_s = S_ERR;
                end
            end
            default: state_next_s = S_IDLE;
        endcase
    end

    // Sequencer state and registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= S_IDLE;
            busy_r      <= 1'b0;
            core_hold_r <= 1'b1;
            done_r      <= 1'b0;
            error_r     <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            busy_r      <= is_busy_state(state_next_s);
            core_hold_r <= (state_next_s != S_DONE);
            if (start_ok_s) begin
                done_r  <= 1'b0;
                error_r <= 1'b0;
            end else if ((state_r == S_CHECK) && (state_next_s == S_DONE)) begin
                done_r  <= 1'b1;
            end else if ((state_r != S_ERR) && (state_next_s == S_ERR)) begin
                error_r <= 1'b1;
            end
        end
    end

    // Length capture, word assembly and running checksum.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_r      <= 16'd0;
            asm_r      <= 24'd0;
            csum_r     <= 8'd0;
            byte_idx_r <= 2'd0;
        end else if (start_ok_s) begin
            len_r      <= 16'd0;
            asm_r      <= 24'd0;
            csum_r     <= 8'd0;
            byte_idx_r <= 2'd0;
        end else if (accept_s) begin
            case (state_r)
                S_LEN_LO: begin
                    len_r[7:0] <= stream.in_data;
                    csum_r     <= checksum_next(csum_r, stream.in_data);
                end
                S_LEN_HI: begin
                    len_r[15:8] <= stream.in_data;
                    csum_r      <= checksum_next(csum_r, stream.in_data);
                end
                S_DATA: begin
                    csum_r     <= checksum_next(csum_r, stream.in_data);
                    byte_idx_r <= byte_idx_r + 2'd1;
                    case (byte_idx_r)
                        2'd0:    asm_r[7:0]   <= stream.in_data;
                        2'd1:    asm_r[15:8]  <= stream.in_data;
                        2'd2:    asm_r[23:16] <= stream.in_data;
                        default: asm_r        <= asm_r;
                    endcase
                end
                default: csum_r <= csum_r;
            endcase
        end
    end

    // Instruction RAM write port: one strobe per completed word, then advance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            imem_we_r      <= 1'b0;
            imem_waddr_r   <= {ADDR_W{1'b0}};
            imem_wdata_r   <= {INSTR_W{1'b0}};
            words_loaded_r <= {(ADDR_W+1){1'b0}};
        end else begin
            imem_we_r <= word_done_s;
            if (word_done_s) begin
                imem_wdata_r <= word_s[INSTR_W-1:0];
            end
            if (start_ok_s) begin
                imem_waddr_r   <= {ADDR_W{1'b0}};
                words_loaded_r <= {(ADDR_W+1){1'b0}};
            end else if (imem_we_r) begin
                imem_waddr_r   <= imem_waddr_r + ADDR_INC;
                words_loaded_r <= words_loaded_r + COUNT_INC;
            end
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Directed self-checking bench for prog_loader (ADDR_W=10, INSTR_W=27).
module tb_prog_loader;
    localparam int ADDR_W  = 10;
    localparam int INSTR_W = 27;
    localparam int DEPTH   = 1 << ADDR_W;

    logic                clk = 1'b0;
    logic                rst;
    logic                start;
    logic                imem_we;
    logic [ADDR_W-1:0]   imem_waddr;
    logic [INSTR_W-1:0]  imem_wdata;
    logic                core_hold;
    logic                busy;
    logic                done;
    logic                error;
    logic [ADDR_W:0]     words_loaded;

    int checks   = 0;
    int failures = 0;

    prog_loader_if sif();

    prog_loader #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .stream(sif.slave),
        .imem_we(imem_we),
        .imem_waddr(imem_waddr),
        .imem_wdata(imem_wdata),
        .core_hold(core_hold),
        .busy(busy),
        .done(done),
        .error(error),
        .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    // Write monitor: bench-side copy of the instruction RAM.
    logic [INSTR_W-1:0] mem [DEPTH];
    int                 wr_total = 0;
    logic [ADDR_W-1:0]  last_addr;

    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            mem[imem_waddr] <= imem_wdata;
            wr_total        <= wr_total + 1;
            last_addr       <= imem_waddr;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Offer one byte from a falling edge, optionally after idle gap cycles;
    // returns at the falling edge right after it was accepted.
    task automatic send_byte(input logic [7:0] b, input int max_gap);
        int guard;
        int gap;
        guard = 0;
        gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
        sif.in_valid = 1'b0;
        repeat (gap) @(negedge clk);
        sif.in_valid = 1'b1;
        sif.in_data  = b;
        while (sif.in_ready !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) begin
            checks++;
            failures++;
            $error("FAIL send_timeout observed=in_ready_low expected=in_ready_high");
        end else begin
            @(negedge clk);
        end
        sif.in_valid = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_ready", sif.in_ready, 1);
        check("start_busy", busy, 1);
    endtask

    // Two-word nominal image with the given checksum byte.
    task automatic load_nominal(input logic [7:0] ck);
        send_byte(8'h02, 0); send_byte(8'h00, 0);
        send_byte(8'h78, 0); send_byte(8'h56, 0); send_byte(8'h34, 0); send_byte(8'h12, 0);
        check("w0_we", imem_we, 1);
        check("w0_addr", imem_waddr, 0);
        check("w0_data", imem_wdata, 27'h2345678);
        send_byte(8'hEF, 0);
        check("w0_once", imem_we, 0);
        send_byte(8'hCD, 0); send_byte(8'hAB, 0); send_byte(8'h09, 0);
        check("w1_we", imem_we, 1);
        check("w1_addr", imem_waddr, 1);
        check("w1_data", imem_wdata, 27'h1ABCDEF);
        check("w1_check_ready", sif.in_ready, 1);
        send_byte(ck, 0);
    endtask

    function automatic logic [31:0] pattern_word(input int i);
        logic [31:0] w;
        w[7:0]   = i[7:0];
        w[15:8]  = 8'h5A;
        w[23:16] = {6'd0, i[9:8]};
        w[31:24] = 8'hF0 ^ i[7:0];
        return w;
    endfunction

    initial begin
        int          base;
        int          bad;
        logic [7:0]  ck;
        logic [31:0] w;

        rst = 1'b1;
        start = 1'b0;
        sif.in_valid = 1'b0;
        sif.in_data = 8'h00;
        repeat (2) @(negedge clk);

        // Reset values
        check("rst_ready", sif.in_ready, 0);
        check("rst_we", imem_we, 0);
        check("rst_waddr", imem_waddr, 0);
        check("rst_wdata", imem_wdata, 0);
        check("rst_hold", core_hold, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_words", words_loaded, 0);

        rst = 1'b0;
        @(negedge clk);
        // IDLE refuses bytes
        sif.in_valid = 1'b1;
        sif.in_data = 8'h55;
        repeat (3) @(negedge clk);
        check("idle_ready", sif.in_ready, 0);
        check("idle_hold", core_hold, 1);
        sif.in_valid = 1'b0;

        // Nominal load at full rate
        base = wr_total;
        do_start();
        load_nominal(8'h8A);
        check("nom_done", done, 1);
        check("nom_error", error, 0);
        check("nom_hold", core_hold, 0);
        check("nom_words", words_loaded, 2);
        check("nom_busy", busy, 0);
        check("nom_writes", wr_total - base, 2);
        check("nom_mem0", mem[0], 27'h2345678);
        check("nom_mem1", mem[1], 27'h1ABCDEF);

        // DONE refuses bytes
        sif.in_valid = 1'b1;
        sif.in_data = 8'hFF;
        repeat (3) @(negedge clk);
        check("done_ready", sif.in_ready, 0);
        check("done_sticky", done, 1);
        check("done_words", words_loaded, 2);
        sif.in_valid = 1'b0;

        // Bad checksum
        base = wr_total;
        do_start();
        load_nominal(8'h8B);
        check("bad_error", error, 1);
        check("bad_done", done, 0);
        check("bad_hold", core_hold, 1);
        check("bad_writes", wr_total - base, 2);

        // Restart clears error; N=3 with random valid gaps
        do_start();
        check("restart_error", error, 0);
        base = wr_total;
        send_byte(8'h03, 2); send_byte(8'h00, 2);
        send_byte(8'h44, 2); send_byte(8'h33, 2); send_byte(8'h22, 2); send_byte(8'h11, 2);
        send_byte(8'hFF, 2); send_byte(8'hFF, 2); send_byte(8'hFF, 2); send_byte(8'hFF, 2);
        send_byte(8'hA5, 2); send_byte(8'hA5, 2); send_byte(8'hA5, 2); send_byte(8'h00, 2);
        send_byte(8'hE2, 2);
        @(negedge clk);
        check("fc_done", done, 1);
        check("fc_writes", wr_total - base, 3);
        check("fc_mem0", mem[0], 27'h1223344);
        check("fc_mem1", mem[1], 27'h7FFFFFF);
        check("fc_mem2", mem[2], 27'h0A5A5A5);
        check("fc_words", words_loaded, 3);

        // N=0
        do_start();
        base = wr_total;
        send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
        check("n0_done", done, 1);
        check("n0_words", words_loaded, 0);
        check("n0_writes", wr_total - base, 0);

        // N = 2**ADDR_W + 1 -> overflow
        do_start();
        base = wr_total;
        send_byte(8'h01, 0); send_byte(8'h04, 0);
        check("ovf_error", error, 1);
        check("ovf_busy", busy, 0);
        check("ovf_done", done, 0);
        repeat (2) @(negedge clk);
        check("ovf_writes", wr_total - base, 0);
        check("ovf_waddr", imem_waddr, 0);

        // N = 2**ADDR_W, with a start pulse during DATA
        do_start();
        base = wr_total;
        ck = 8'h04;
        send_byte(8'h00, 0); send_byte(8'h04, 0);
        for (int i = 0; i < DEPTH; i++) begin
            w = pattern_word(i);
            for (int k = 0; k < 4; k++) begin
                if (i == 5 && k == 0) start = 1'b1;
                send_byte(w[8*k +: 8], 0);
                ck = ck ^ w[8*k +: 8];
                if (i == 5 && k == 0) begin
                    start = 1'b0;
                    check("mid_start_busy", busy, 1);
                    check("mid_start_words", words_loaded, 5);
                end
            end
        end
        send_byte(ck, 0);
        check("full_done", done, 1);
        check("full_words", words_loaded, DEPTH);
        check("full_writes", wr_total - base, DEPTH);
        check("full_last_addr", last_addr, DEPTH - 1);
        check("full_waddr_wrap", imem_waddr, 0);
        bad = 0;
        for (int i = 0; i < DEPTH; i++) begin
            w = pattern_word(i);
            if (mem[i] !== w[INSTR_W-1:0]) bad++;
        end
        check("full_mem_bad", bad, 0);

        // Reset mid-load with a write in flight
        do_start();
        send_byte(8'h02, 0); send_byte(8'h00, 0);
        send_byte(8'h78, 0); send_byte(8'h56, 0); send_byte(8'h34, 0); send_byte(8'h12, 0);
        check("mid_inflight", imem_we, 1);
        #1 rst = 1'b1;
        #1;
        check("mid_rst_we", imem_we, 0);
        check("mid_rst_waddr", imem_waddr, 0);
        check("mid_rst_wdata", imem_wdata, 0);
        check("mid_rst_ready", sif.in_ready, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_hold", core_hold, 1);
        check("mid_rst_done", done, 0);
        check("mid_rst_error", error, 0);
        check("mid_rst_words", words_loaded, 0);
        base = wr_total;
        repeat (3) @(negedge clk);
        check("mid_rst_nowrite", wr_total - base, 0);
        rst = 1'b0;
        @(negedge clk);
        base = wr_total;
        do_start();
        load_nominal(8'h8A);
        check("post_rst_done", done, 1);
        check("post_rst_writes", wr_total - base, 2);
        check("post_rst_words", words_loaded, 2);
        check("post_rst_mem0", mem[0], 27'h2345678);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/prog_loader.md
# prog_loader

Byte-stream program loader that writes 27-bit instructions into the core's instruction RAM. It is the write-side counterpart of the instruction fetch path: the program counter reads instruction words, and this block fills them. It accepts a length-prefixed, XOR-checksummed byte stream over a valid/ready handshake. It holds the core in reset until a complete, verified image has been written.

## Interface
Parameters:
- ADDR_W, 10, instruction RAM address width (depth 2**ADDR_W words)
- INSTR_W, 27, instruction width; must be ≤ 32

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  single-cycle load request
- in_valid  in  1  byte available on in_data
- in_data  in  8  stream byte
- in_ready  out  1  loader can accept a byte this cycle
- imem_we  out  1  instruction RAM write strobe, one cycle per word
- imem_waddr  out  ADDR_W  write address
- imem_wdata  out  INSTR_W  write data
- core_hold  out  1  high: core must be held in reset
- busy  out  1  load in progress
- done  out  1  image loaded and checksum verified (sticky)
- error  out  1  load aborted (sticky)
- words_loaded  out  ADDR_W+1  count of words written in the current/last load

## Operation
- States: IDLE, LEN_LO, LEN_HI, DATA, CHECK, DONE, ERR.
- A byte is accepted on any clk edge where in_valid & in_ready. in_ready=1 only in LEN_LO, LEN_HI, DATA and CHECK.
- IDLE/DONE/ERR, start=1 -> LEN_LO. This clears done, error, words_loaded, the byte counter and the checksum, and sets imem_waddr=0. start is ignored in every other state.
- LEN_LO: accepted byte -> N[7:0]; -> LEN_HI.
- LEN_HI: accepted byte -> N[15:8]. Next state by N:
  - N > 2**ADDR_W -> ERR.
  - N == 0 -> CHECK.
  - otherwise -> DATA.
- DATA: bytes are little-endian, 4 per word. Byte 0 -> bits[7:0], byte 1 -> [15:8], byte 2 -> [23:16], byte 3 -> [31:24]. Bits above INSTR_W-1 are discarded.
- On acceptance of byte 3 of a word:
  - the next cycle presents imem_we=1 with the assembled word at the current imem_waddr;
  - after that write, imem_waddr increments and words_loaded increments.
  - When words_loaded reaches N, the state goes -> CHECK. The last address written is N-1; imem_waddr wraps to 0 only when N = 2**ADDR_W.
- Checksum: XOR of every accepted byte from LEN_LO through the last DATA byte.
- CHECK: accepted byte == running checksum -> DONE (done=1), otherwise -> ERR (error=1).
- core_hold=0 only in DONE; it is 1 in every other state, including IDLE after reset.
- busy=1 in LEN_LO, LEN_HI, DATA, CHECK.
- Words already written before an ERR are not rolled back.

## Timing
- Reset values: state IDLE, in_ready=0, imem_we=0, imem_waddr=0, imem_wdata=0, core_hold=1, busy=0, done=0, error=0, words_loaded=0.
- start sampled at cycle t -> in_ready=1 and busy=1 at t+1.
- Full throughput: one byte per cycle with no bubbles, including the cycle in which imem_we is asserted.
- Write latency: imem_we is asserted in the cycle after byte 3 of a word is accepted, exactly once per word. imem_waddr and imem_wdata are stable while imem_we=1.
- Back-to-back words at full rate produce imem_we high 1 of every 4 cycles.
- done and error are set in the cycle after the checksum byte is accepted. core_hold falls together with done.
- LEN_HI overflow -> ERR: error=1 one cycle after the length byte is accepted; no write occurs.
- The last word's write strobe is issued even though the state has moved to CHECK. If the checksum byte is accepted in that same cycle, the write still completes.
- Asynchronous rst at any point returns all state and outputs to reset values immediately. Any write in flight is dropped.

## Test plan
- Reset mid-load: assert rst during DATA after 6 bytes -> all outputs at reset values; no further imem_we; a fresh start loads normally.
- Nominal load, full rate: start, then bytes 02 00, 78 56 34 12, EF CD AB 09, checksum = XOR of all 10 bytes ->
  - imem_we at addr 0, data 27'h2345678 (top bits of 0x12345678 masked);
  - imem_we at addr 1, data 27'h1ABCDEF;
  - words_loaded=2, done=1, core_hold=0, error=0.
- Bad checksum: same stream with checksum byte XOR 01 -> both words written, then error=1, done=0, core_hold=1. A second start clears error.
- Flow control: in_valid toggled randomly while loading N=3 -> correct data at addrs 0..2; imem_we exactly 3 pulses; no byte is accepted while in_ready=0 (in IDLE or DONE).
- Boundaries:
  - N=0 with checksum 00 -> done=1, no writes.
  - N=2**ADDR_W+1 -> error=1 after LEN_HI, no writes.
  - N=2**ADDR_W -> last write at addr 2**ADDR_W-1, words_loaded=2**ADDR_W.
  - start pulsed during DATA -> ignored.
